// File: rtl/change_capture_pkg.sv
// change_capture_pkg: shared default widths, FSM states and record layout
package change_capture_pkg;
  localparam int CC_DATA_W = 4;
  localparam int CC_TS_W = 16;
  localparam int CC_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  typedef struct packed {
    logic [CC_DATA_W-1:0] data;
    logic [CC_TS_W-1:0] ts;
    logic first;
  } rec_t;
endpackage

// File: rtl/change_capture_if.sv
// change_capture_if: control inputs, record stream and status of the change capture block
interface change_capture_if import change_capture_pkg::*; #(
  parameter int DATA_W = CC_DATA_W,
  parameter int TS_W = CC_TS_W,
  parameter int DEPTH = CC_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic en, clear, out_ready, out_valid, out_first, overflow;
  logic [DATA_W-1:0] sample_in, out_data;
  logic [TS_W-1:0] out_ts;
  logic [LW-1:0] level;
  modport master(output en, clear, sample_in, out_ready,
                 input out_valid, out_data, out_ts, out_first, overflow, level);
  modport slave(input en, clear, sample_in, out_ready,
                output out_valid, out_data, out_ts, out_first, overflow, level);
endinterface

// File: rtl/cc_fifo.sv
// cc_fifo: first-word fall-through record FIFO with flush; a full FIFO accepts a push only alongside a pop
module cc_fifo #(
  parameter int W = 21,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/change_capture.sv
// change_capture: timestamps every change of a monitored bus after an initial dump and queues the records
module change_capture import change_capture_pkg::*; #(
  parameter int DATA_W = CC_DATA_W,
  parameter int TS_W = CC_TS_W,
  parameter int DEPTH = CC_DEPTH,
  localparam int RW = DATA_W + TS_W + 1
) (
  input logic clk,
  input logic rstn,
  change_capture_if.slave bus
);
  state_t state, state_nx;
  logic [TS_W-1:0] ts;
  logic [DATA_W-1:0] last_val;
  logic [RW-1:0] push_rec, head;
  logic push, pop, full, empty;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = !bus.en ? IDLE : (state == IDLE ? PRIME : RUN);
  always_comb begin
    push = bus.en && (state == PRIME || (state == RUN && bus.sample_in != last_val));
    push_rec = {bus.sample_in, state == PRIME ? {TS_W{1'b0}} : ts, state == PRIME};
  end
  // last_val follows every detected change, even when the record itself is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts <= '0;
      last_val <= '0;
    end else begin
      if (bus.en && state != IDLE) ts <= state == PRIME ? TS_W'(1) : ts + 1'b1;
      if (push) last_val <= bus.sample_in;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) bus.overflow <= 1'b0;
    else if (bus.clear) bus.overflow <= 1'b0;
    else if (push && full && !pop) bus.overflow <= 1'b1;
  assign pop = ~empty & bus.out_ready;
  cc_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .flush(bus.clear),
    .din(push_rec), .dout(head), .full(full), .empty(empty), .level(bus.level)
  );
  assign bus.out_valid = ~empty;
  assign bus.out_data = empty ? '0 : head[RW-1 -: DATA_W];
  assign bus.out_ts = empty ? '0 : head[TS_W:1];
  assign bus.out_first = ~empty & head[0];
endmodule

// File: tb/tb_change_capture.sv
// tb_change_capture: directed vector table plus hand-written corner sequences for change_capture
module tb_change_capture;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  change_capture_if bus();
  change_capture dut(.clk(clk), .rstn(rstn), .bus(bus));
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic v;
    logic [3:0] d;
    logic [15:0] ts;
    logic f;
    logic [3:0] lvl;
    logic o;
  } obs_t;
  typedef struct {
    logic en;
    logic clr;
    logic rdy;
    logic [3:0] s;
    obs_t exp;
  } vec_t;
  function automatic obs_t rec_o(logic [3:0] d, logic [15:0] t, logic f, logic [3:0] l, logic o);
    return {1'b1, d, t, f, l, o};
  endfunction
  function automatic obs_t empty_o(logic [3:0] l, logic o);
    return {1'b0, 4'h0, 16'h0, 1'b0, l, o};
  endfunction
  function automatic obs_t observe();
    return {bus.out_valid, bus.out_data, bus.out_ts, bus.out_first, bus.level, bus.overflow};
  endfunction
  task automatic chk(string name, obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%0h ts=%0h f=%0b lvl=%0d ovf=%0b, expected v=%0b d=%0h ts=%0h f=%0b lvl=%0d ovf=%0b",
               name, act.v, act.d, act.ts, act.f, act.lvl, act.o, exp.v, exp.d, exp.ts, exp.f, exp.lvl, exp.o);
    end
  endtask
  task automatic chk_lo(string name, logic [3:0] lvl, logic o);
    checks++;
    if (bus.level !== lvl || bus.overflow !== o) begin
      errors++;
      $display("FAIL %s: got lvl=%0d ovf=%0b, expected lvl=%0d ovf=%0b", name, bus.level, bus.overflow, lvl, o);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  vec_t tv[15];
  initial begin
    bus.en = 1'b0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    bus.sample_in = 4'h0;
    tv[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, empty_o(0, 0)};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, rec_o(4'h0, 16'd0, 1, 1, 0)};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, rec_o(4'h0, 16'd0, 1, 1, 0)};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 4'h3, rec_o(4'h0, 16'd0, 1, 2, 0)};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 4'h3, rec_o(4'h3, 16'd2, 0, 1, 0)};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 4'h3, empty_o(0, 0)};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 4'h5, rec_o(4'h5, 16'd5, 0, 1, 0)};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 4'h5, empty_o(0, 0)};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 4'h9, empty_o(0, 0)};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 4'h2, empty_o(0, 0)};
    tv[10] = '{1'b1, 1'b0, 1'b0, 4'h2, empty_o(0, 0)};
    tv[11] = '{1'b1, 1'b0, 1'b0, 4'h2, rec_o(4'h2, 16'd0, 1, 1, 0)};
    tv[12] = '{1'b1, 1'b1, 1'b0, 4'h7, empty_o(0, 0)};
    tv[13] = '{1'b1, 1'b0, 1'b0, 4'h8, rec_o(4'h8, 16'd2, 0, 1, 0)};
    tv[14] = '{1'b1, 1'b0, 1'b1, 4'h8, empty_o(0, 0)};
    #2;
    chk("reset_state", empty_o(0, 0));
    step();
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.en = tv[i].en;
      bus.clear = tv[i].clr;
      bus.out_ready = tv[i].rdy;
      bus.sample_in = tv[i].s;
      step();
      chk($sformatf("vec%0d", i), tv[i].exp);
    end
    bus.clear = 1'b0;
    // fresh start: initial dump then a change every 5 cycles
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    bus.en = 1'b1;
    bus.sample_in = 4'h0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("prime_dump", rec_o(4'h0, 16'd0, 1, 1, 0));
    for (int c = 1; c <= 60; c++) begin
      bus.sample_in = 4'(c / 5);
      step();
      chk($sformatf("ramp_ts%0d", c), (c % 5 == 0) ? rec_o(4'(c / 5), 16'(c), 0, 1, 0) : empty_o(0, 0));
    end
    step();
    chk("ramp_drain", empty_o(0, 0));
    // backpressure with a toggle every cycle: the oldest 8 survive
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.sample_in = (k % 2 == 0) ? 4'hD : 4'hC;
      step();
    end
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("retained%0d", j), rec_o((j % 2 == 0) ? 4'hD : 4'hC, 16'(62 + j), 0, 4'(8 - j), 1));
      bus.out_ready = 1'b1;
      step();
    end
    chk("drained_sticky", empty_o(0, 1));
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.sample_in = (k % 2 == 0) ? 4'hD : 4'hC;
      step();
    end
    chk_lo("refill_ovf", 4'd8, 1'b1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_full", empty_o(0, 0));
    for (int k = 0; k < 8; k++) begin
      bus.sample_in = (k % 2 == 0) ? 4'hC : 4'hD;
      step();
    end
    chk_lo("full_no_ovf", 4'd8, 1'b0);
    bus.out_ready = 1'b1;
    bus.sample_in = 4'hC;
    step();
    chk_lo("full_push_pop", 4'd8, 1'b0);
    bus.out_ready = 1'b0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_again", empty_o(0, 0));
    // timestamp wrap
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    bus.sample_in = 4'h0;
    bus.out_ready = 1'b1;
    step();
    step();
    repeat (65534) @(posedge clk);
    #1;
    bus.sample_in = 4'h1;
    step();
    chk("wrap_ffff", rec_o(4'h1, 16'hFFFF, 0, 1, 0));
    step();
    chk("wrap_zero_idle", empty_o(0, 0));
    bus.sample_in = 4'h0;
    step();
    chk("wrap_0001", rec_o(4'h0, 16'h0001, 0, 1, 0));
    // asynchronous reset with records buffered
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.sample_in = 4'(k);
      step();
    end
    chk("three_buffered", rec_o(4'h0, 16'h0001, 0, 4, 0));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", empty_o(0, 0));
    #1;
    rstn = 1'b1;
    bus.sample_in = 4'h6;
    step();
    step();
    chk("post_reset_dump", rec_o(4'h6, 16'd0, 1, 1, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/change_capture.md
CHANGE_CAPTURE -- requirements
Module: change_capture

Interface
REQ-001 Parameter DATA_W, default 4: width of the monitored bus.
REQ-002 Parameter TS_W, default 16: width of the cycle timestamp.
REQ-003 Parameter DEPTH, default 8: record FIFO depth, power of two.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rstn  in  1: asynchronous, active-low reset.
REQ-006 en  in  1: capture enable; level-sensitive.
REQ-007 clear  in  1: one-cycle pulse; flushes the FIFO and clears overflow.
REQ-008 sample_in  in  DATA_W: monitored bus, sampled every rising edge.
REQ-009 out_valid  out  1: head record available.
REQ-010 out_ready  in  1: consumer accepts the head record.
REQ-011 out_data  out  DATA_W: captured bus value.
REQ-012 out_ts  out  TS_W: cycle timestamp of the capture.
REQ-013 out_first  out  1: record is the initial dump after enable.
REQ-014 overflow  out  1: sticky; at least one change was dropped.
REQ-015 level  out  clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-016 FSM states: IDLE, PRIME, RUN; reset state IDLE.
REQ-017 IDLE: no captures, timestamp held; go to PRIME when en=1.
REQ-018 PRIME (one cycle): push {sample_in, ts=0, first=1} unconditionally, load last_val with sample_in, ts becomes 1, go to RUN.
REQ-019 RUN: at each edge, if sample_in != last_val, push {sample_in, ts, first=0} and update last_val; ts increments every edge.
REQ-020 RUN or PRIME with en=0: go to IDLE at that edge with no push; a later en=1 re-enters PRIME and restarts ts at 0.
REQ-021 Timestamp wraps from all-ones to zero with no flag and no stall.
REQ-022 Handshake: a record transfers on any edge with out_valid=1 and out_ready=1; out_data, out_ts and out_first hold stable while out_valid=1 and out_ready=0.
REQ-023 FIFO is first-word fall-through: a record pushed at edge k drives out_valid=1 from edge k until popped (latency 1 edge from sampling).
REQ-024 Push when full with no pop in the same cycle: record dropped, last_val still updated, overflow set to 1.
REQ-025 Push and pop in the same cycle when full: both succeed; level unchanged; overflow unchanged.
REQ-026 Push and pop in the same cycle when empty: the record is written, and out_valid=1 after the edge.
REQ-027 clear=1: FIFO empties, level=0, and overflow=0 at that edge; a simultaneous push is discarded; FSM state, ts and last_val are unaffected.
REQ-028 overflow stays at 1 until clear or reset.

Reset
REQ-029 rstn=0 immediately forces: state IDLE, ts=0, last_val=0, FIFO empty, out_valid=0, out_data=0, out_ts=0, out_first=0, overflow=0, level=0.
REQ-030 Reset asserted mid-operation discards all buffered records; after release the block waits in IDLE for en.

Structure
REQ-031 Package change_capture_pkg holds DATA_W, TS_W and DEPTH defaults, the state enum, and the record struct {data, ts, first}.
REQ-032 One sub-module, cc_fifo: a synchronous FWFT FIFO of records with push, pop, full, empty, level and flush; the FSM, timestamp and compare logic stay in change_capture.

Verification
REQ-033 Bench reset, then en=1, sample_in=0, out_ready=1 -> one record {0, ts=0, first=1}; no further records while sample_in is constant.
REQ-034 sample_in increments by 1 every 5 cycles from 0 for 60 cycles -> records with data 1,2,3... and ts 5,10,15...; first=0 after the first record.
REQ-035 out_ready=0, sample_in toggles every cycle for 12 cycles -> level reaches 8, overflow=1, and the 8 retained records are the oldest 8 in order; clear -> level=0, overflow=0.
REQ-036 FIFO full with out_ready=1 and a change in the same cycle -> level stays 8 and overflow stays 0.
REQ-037 Hold en=1 past 65536 cycles and change sample_in at ts 0xFFFF and again 2 cycles later -> out_ts 0xFFFF then 0x0001.
REQ-038 rstn=0 asynchronously with 3 records buffered -> out_valid=0 and level=0 before the next clock edge; after release with en=1 -> a fresh first=1 record with ts=0.
